// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, request/response handshake, in-order instruction queue, redirect drain.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets via misalign_fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] next_instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        misalign_fault
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_t;

  state_t        state_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   last_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] q_head_r;
  logic [PW-1:0] q_tail_r;
  logic [PW-1:0] if_head_r;
  logic [PW-1:0] if_tail_r;
  logic [31:0]   q_inst_r [QUEUE_DEPTH];
  logic [31:0]   q_pc_r   [QUEUE_DEPTH];
  logic [31:0]   if_pc_r  [QUEUE_DEPTH];
  logic          fault_r;

  logic [31:0]   target_s;
  logic          misalign_s;
  logic          has_head_s;
  logic          pop_s;
  logic          resp_s;
  logic          push_s;
  logic          req_s;
  logic          accept_s;
  logic [CW:0]   credit_sum_s;
  logic [CW-1:0] drop_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_s       = redirect_pc;
  assign misalign_s     = (redirect_pc[1:0] != 2'b00);
  assign misalign_fault = fault_r;
`else
  assign target_s       = redirect_pc & 32'hFFFF_FFFC;
  assign misalign_s     = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  assign has_head_s   = (count_r != {CW{1'b0}});
  assign pop_s        = has_head_s && !stall;
  assign resp_s       = imem_rvalid && (outstanding_r != {CW{1'b0}});
  assign push_s       = (state_r == RUN) && resp_s && !redirect;
  // An entry popped this cycle is free before any new request can be answered.
  assign credit_sum_s = {1'b0, outstanding_r} + {1'b0, count_r} - {{CW{1'b0}}, pop_s};
  assign req_s        = (state_r == RUN) && !redirect && !fault_r &&
                        (credit_sum_s < (CW+1)'(QUEUE_DEPTH));
  assign accept_s     = req_s && imem_ready;
  assign drop_s       = outstanding_r - {{(CW-1){1'b0}}, resp_s};

  assign imem_req         = req_s;
  assign imem_addr        = fetch_pc_r & 32'hFFFF_FFFC;
  assign next_instruction = has_head_s ? q_inst_r[q_head_r] : NOP;
  assign pc_out           = has_head_s ? q_pc_r[q_head_r] : last_pc_r;
  assign inst_valid       = has_head_s;

  // Fetch state machine, PC, credit counters, in-flight PC FIFO and instruction queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      last_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      count_r       <= {CW{1'b0}};
      q_head_r      <= {PW{1'b0}};
      q_tail_r      <= {PW{1'b0}};
      if_head_r     <= {PW{1'b0}};
      if_tail_r     <= {PW{1'b0}};
      fault_r       <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst_r[i] <= NOP;
        q_pc_r[i]   <= 32'h0000_0000;
        if_pc_r[i]  <= 32'h0000_0000;
      end
    end else begin
      last_pc_r <= pc_out;
      if (redirect) begin
        fetch_pc_r    <= target_s;
        fault_r       <= misalign_s;
        count_r       <= {CW{1'b0}};
        q_head_r      <= {PW{1'b0}};
        q_tail_r      <= {PW{1'b0}};
        if_head_r     <= {PW{1'b0}};
        if_tail_r     <= {PW{1'b0}};
        outstanding_r <= drop_s;
        state_r       <= (drop_s != {CW{1'b0}}) ? DRAIN : RUN;
      end else begin
        case (state_r)
          BOOT: begin
            state_r <= RUN;
          end
          RUN: begin
            if (accept_s) begin
              fetch_pc_r          <= fetch_pc_r + 32'd4;
              if_pc_r[if_tail_r]  <= imem_addr;
              if_tail_r           <= if_tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (push_s) begin
              q_inst_r[q_tail_r] <= imem_rdata;
              q_pc_r[q_tail_r]   <= if_pc_r[if_head_r];
              q_tail_r           <= q_tail_r + {{(PW-1){1'b0}}, 1'b1};
              if_head_r          <= if_head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
              q_head_r <= q_head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            outstanding_r <= outstanding_r + {{(CW-1){1'b0}}, accept_s}
                                           - {{(CW-1){1'b0}}, push_s};
            count_r       <= count_r + {{(CW-1){1'b0}}, push_s}
                                     - {{(CW-1){1'b0}}, pop_s};
          end
          DRAIN: begin
            outstanding_r <= drop_s;
            if (drop_s == {CW{1'b0}}) begin
              state_r <= RUN;
            end
          end
          default: begin
            state_r <= BOOT;
          end
        endcase
      end
    end
  end
endmodule
